// File: rtl/mpi_pkg.sv
// Types and constants shared by the CPU parallel-bus slave controller.
package mpi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } mpi_state_e;

  // Read data returned to the CPU when the register side never answers.
  localparam logic [31:0] MPI_ERR_DATA = 32'hDEAD_BEEF;

  // Fewer than two flops on an async strobe is not a synchroniser.
  localparam int MPI_MIN_SYNC = 2;

endpackage

// File: rtl/mpi_slave_ctrl_if.sv
// Internal register bus: one req/ack transaction per CPU access.
interface mpi_slave_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              reg_req;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_ack;

  // master = bus controller issuing requests, slave = register file
  modport master (output reg_req, reg_wr, reg_addr, reg_wdata,
                  input  reg_rdata, reg_ack);
  modport slave  (input  reg_req, reg_wr, reg_addr, reg_wdata,
                  output reg_rdata, reg_ack);
endinterface

// File: rtl/mpi_sync.sv
// N-stage synchroniser, resets to 1 so idle-high strobes look inactive.
module mpi_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 3
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] ff;

  // shift chain: stage 0 takes the async input, last stage is the output
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      ff <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/mpi_slave_ctrl.sv
// CPU parallel-bus target: turns each CPU read/write into one register-bus
// req/ack transaction and answers the CPU with rdy_n, with a response timeout.
module mpi_slave_ctrl
  import mpi_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] ERR_DATA    = MPI_ERR_DATA
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              cpu_cs_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_we_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_data_oe,
  output logic              cpu_rdy_n,
  mpi_slave_ctrl_if.master  reg_bus,
  output logic              timeout_err,
  input  logic              err_clr
);
  localparam int SYNC_N = (SYNC_STAGES < MPI_MIN_SYNC) ? MPI_MIN_SYNC : SYNC_STAGES;
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [DATA_W-1:0] ERR_VAL = DATA_W'(ERR_DATA);

  logic cs_s, rd_s, we_s;

  mpi_sync #(.STAGES(SYNC_N), .WIDTH(3)) u_sync (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .d        ({cpu_cs_n, cpu_rd_n, cpu_we_n}),
    .q        ({cs_s, rd_s, we_s})
  );

  mpi_state_e        state, state_nxt;
  logic              req_q, req_nxt, wr_q, wr_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt, dout_nxt;
  logic              oe_nxt, rdy_nxt, err_nxt, err_set;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              access_ok, expire;

  // exactly one strobe low under chip select; both low is illegal
  assign access_ok = !cs_s && (rd_s ^ we_s);
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign expire    = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));

  // next-state and next-output decode
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    wr_nxt    = wr_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    dout_nxt  = cpu_data_o;
    oe_nxt    = cpu_data_oe;
    rdy_nxt   = cpu_rdy_n;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    case (state)
      IDLE: if (access_ok) begin
        state_nxt = REQ;
        addr_nxt  = cpu_addr;
        wdata_nxt = cpu_data_i;
        wr_nxt    = ~we_s;
        req_nxt   = 1'b1;
        cnt_nxt   = '0;
      end
      REQ: begin
        // ack beats a simultaneous expiry
        if (reg_bus.reg_ack) begin
          state_nxt = HOLD;
          req_nxt   = 1'b0;
          rdy_nxt   = 1'b0;
          if (!wr_q) begin
            dout_nxt = reg_bus.reg_rdata;
            oe_nxt   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_inc;
          if (expire) begin
            state_nxt = HOLD;
            req_nxt   = 1'b0;
            rdy_nxt   = 1'b0;
            err_set   = 1'b1;
            if (!wr_q) begin
              dout_nxt = ERR_VAL;
              oe_nxt   = 1'b1;
            end
          end
        end
      end
      HOLD: if (cs_s) begin
        state_nxt = IDLE;
        rdy_nxt   = 1'b1;
        oe_nxt    = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
    // set wins over a simultaneous clear
    err_nxt = err_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err);
  end

  // state and registered outputs
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_data_o  <= '0;
      cpu_data_oe <= 1'b0;
      cpu_rdy_n   <= 1'b1;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_q       <= req_nxt;
      wr_q        <= wr_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      cpu_data_o  <= dout_nxt;
      cpu_data_oe <= oe_nxt;
      cpu_rdy_n   <= rdy_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= err_nxt;
    end
  end

  assign reg_bus.reg_req   = req_q;
  assign reg_bus.reg_wr    = wr_q;
  assign reg_bus.reg_addr  = addr_q;
  assign reg_bus.reg_wdata = wdata_q;
endmodule
